// File: rtl/frame_writer_pkg.sv
// Shared frame geometry and capture state encoding for the
// frame writer, readout block and frame memory.
package frame_writer_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/count_frame_writer_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/count_frame_writer.sv
// Writes a handshaked stream of photon-count samples into
// consecutive frame memory words and flags frame completion.
module count_frame_writer
  import frame_writer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic [7:0]        dropped
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_e state_q, state_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic capturing;
  logic xfer;
  logic arm_ok;
  logic last;

  // Zero or oversize lengths mean a full-depth frame.
  function automatic logic [LEN_W-1:0] eff_len(
    input logic [LEN_W-1:0] fl
  );
    if ((fl == '0) || (fl > DEPTH_L)) begin
      return DEPTH_L;
    end
    return fl;
  endfunction

  assign capturing = (state_q == CAPTURE);
  assign xfer      = in_valid & capturing & ~abort;
  assign arm_ok    = arm & ~abort & ~capturing;
  assign last      = (cnt_q == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (arm) state_d = CAPTURE;
        end
        CAPTURE: begin
          if (xfer && last) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = capturing;
    busy     = capturing;
  end

  // The write address is the running sample count itself.
  always_comb begin
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    we_d    = xfer;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (abort) begin
      done_d = 1'b0;
    end else if (arm_ok) begin
      len_d  = eff_len(frame_len);
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (xfer) begin
      waddr_d = cnt_q[ADDR_W-1:0];
      wdata_d = in_data;
      cnt_d   = cnt_q + LEN_W'(1);
      if (last) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  sat_counter #(
    .W(8)
  ) u_drop (
    .clk  (clk),
    .rst  (rst),
    .inc  (in_valid & ~capturing),
    .clr  (arm_ok),
    .count(dropped)
  );

  assign mem_we    = we_q;
  assign mem_addr  = waddr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign wr_count  = cnt_q;

endmodule

// File: tb/tb_count_frame_writer.sv
// Randomised and directed stimulus for count_frame_writer,
// checked every cycle against a sample-level reference model.
module tb_count_frame_writer;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        abort;
  logic [10:0] frame_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [10:0] wr_count;
  logic [7:0]  dropped;

  int n_vec = 0;
  int n_err = 0;

  // reference model: frame progress in samples
  bit m_cap;
  bit m_done;
  int m_len;
  int m_cnt;
  int m_drop;
  bit m_we;
  int m_addr;
  int m_wd;

  count_frame_writer dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .abort    (abort),
    .frame_len(frame_len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count),
    .dropped  (dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cap  = 0;
    m_done = 0;
    m_len  = 0;
    m_cnt  = 0;
    m_drop = 0;
    m_we   = 0;
    m_addr = 0;
    m_wd   = 0;
  endtask

  task automatic model_step(input bit a, input bit ab, input bit v,
                            input int d, input int fl);
    if (!m_cap && v && m_drop < 255) m_drop++;
    m_we = 0;
    if (ab) begin
      m_cap  = 0;
      m_done = 0;
    end else if (m_cap) begin
      if (v) begin
        m_we   = 1;
        m_addr = m_cnt;
        m_wd   = d & 16'hffff;
        m_cnt++;
        if (m_cnt == m_len) begin
          m_cap  = 0;
          m_done = 1;
        end
      end
    end else if (a) begin
      m_cap  = 1;
      m_len  = (fl == 0 || fl > 1024) ? 1024 : fl;
      m_cnt  = 0;
      m_done = 0;
      m_drop = 0;
    end
  endtask

  task automatic check_outputs();
    check("in_ready", in_ready, m_cap);
    check("busy", busy, m_cap);
    check("done", done, m_done);
    check("wr_count", wr_count, m_cnt);
    check("dropped", dropped, m_drop);
    check("mem_we", mem_we, m_we);
    if (m_we) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wd);
    end
  endtask

  task automatic cyc(input bit a, input bit ab, input bit v,
                     input int d, input int fl);
    @(negedge clk);
    check_outputs();
    arm       = a;
    abort     = ab;
    in_valid  = v;
    in_data   = d[15:0];
    frame_len = fl[10:0];
    model_step(a, ab, v, d, fl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_dropped", dropped, 0);
    arm      = 0;
    abort    = 0;
    in_valid = 0;
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    arm       = 0;
    abort     = 0;
    frame_len = '0;
    in_valid  = 0;
    in_data   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    // four-sample frame, valid held high
    cyc(1, 0, 0, 0, 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 10 + i, 0);
    cyc(0, 0, 1, 99, 0);
    idle(1);
    check("s1_done", done, 1);
    check("s1_count", wr_count, 4);

    // zero and oversize lengths give full-depth frames
    for (int k = 0; k < 2; k++) begin
      cyc(1, 0, 0, 0, (k == 0) ? 0 : 2000);
      for (int i = 0; i < 1030; i++) cyc(0, 0, 1, $urandom, 0);
      idle(1);
      check("full_count", wr_count, 1024);
      check("full_done", done, 1);
    end

    // gapped input stream
    cyc(1, 0, 0, 0, 8);
    for (int i = 0; i < 20; i++) cyc(0, 0, i % 2, $urandom, 0);
    idle(2);

    // abort after three samples, then restart from zero
    cyc(1, 0, 0, 0, 8);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 40 + i, 0);
    cyc(0, 1, 1, 77, 0);
    idle(2);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    cyc(1, 0, 0, 0, 8);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 50 + i, 0);

    // drop counter saturation, clear on arm, arm ignored mid-frame
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, 0, 0);
    idle(1);
    check("drop_sat", dropped, 255);
    cyc(1, 0, 0, 0, 6);
    cyc(0, 0, 1, 1, 0);
    check("drop_clr", dropped, 0);
    cyc(0, 0, 1, 2, 0);
    cyc(1, 0, 1, 3, 3);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 4 + i, 0);
    idle(1);
    check("arm_ignored_count", wr_count, 6);

    // asynchronous reset mid-frame
    cyc(1, 0, 0, 0, 8);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 60 + i, 0);
    async_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 70, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit a, ab, v;
      int fl;
      a  = ($urandom % 40) == 0;
      ab = ($urandom % 97) == 0;
      v  = ($urandom % 3) != 0;
      fl = (($urandom % 5) == 0) ? int'($urandom_range(0, 2047))
                                 : int'($urandom_range(1, 20));
      cyc(a, ab, v, $urandom, fl);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
